// File: rtl/daq_packetizer_pkg.sv
// Shared constants, FSM state type and packet word builder for the DAQ packetizer.
package daq_packetizer_pkg;

  localparam logic [7:0]  HDR       = 8'hA5;
  localparam int unsigned PKT_WORDS = 11;
  localparam int unsigned PKT_BYTES = 22;
  localparam int unsigned MAX_OS    = 6;

  typedef enum logic {IDLE, SEND} state_t;

  // Word idx of a packet; idx 10 is the XOR of words 1..9.
  function automatic logic [15:0] pkt_word(input logic [3:0]  idx,
                                           input logic [2:0]  os,
                                           input logic [15:0] cnt);
    logic [15:0] w;
    logic [15:0] csum;
    logic [3:0]  k;
    csum = cnt;
    for (int unsigned j = 0; j < 8; j++) begin
      csum ^= {j[2:0], cnt[12:0]};
    end
    k = idx - 4'd2;
    case (idx)
      4'd0:    w = {HDR, 5'b0, os};
      4'd1:    w = cnt;
      4'd10:   w = csum;
      default: w = {k[2:0], cnt[12:0]};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/daq_byte_fifo.sv
// Single-clock show-ahead byte FIFO with free-space output.
module daq_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        push_i,
  input  logic [7:0]                  push_data_i,
  input  logic                        pop_i,
  output logic                        empty_o,
  output logic [7:0]                  data_o,
  output logic [$clog2(FIFO_DEPTH):0] free_o
);

  localparam int unsigned  AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  DEPTH_L = FIFO_DEPTH[AW:0];

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    last_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && ((count_q != DEPTH_L) || do_pop);
  assign free_o  = DEPTH_L - count_q;
  // When empty, keep presenting the last byte popped (0 after reset).
  assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: rtl/daq_packetizer.sv
// DAQ packet generator: periodic 11-word packets on db_o plus a big-endian byte copy in a FIFO.
module daq_packetizer
  import daq_packetizer_pkg::*;
#(
  parameter int unsigned BASE_PERIOD = 1000,
  parameter int unsigned FIFO_DEPTH  = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [2:0]  os_sel_i,
  input  logic        en_i,
  output logic [15:0] db_o,
  output logic        rdreq_o,
  output logic        wrclk_o,
  output logic        fifo_out_empty,
  input  logic        fifo_out_req,
  output logic [7:0]  fifo_out_data
);

  localparam int unsigned   TW    = $clog2(BASE_PERIOD << MAX_OS) + 1;
  localparam int unsigned   FAW   = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] BASE  = BASE_PERIOD[TW-1:0];
  localparam logic [TW-1:0] ONE   = 1;
  localparam logic [FAW:0]  NEED  = PKT_BYTES[FAW:0];
  localparam logic [3:0]    LAST  = PKT_WORDS[3:0] - 4'd1;
  localparam logic [2:0]    OSMAX = MAX_OS[2:0];

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW-1:0] period_m1;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   cnt_lat_q, cnt_lat_d;
  logic [2:0]    os_q, os_d;
  logic [2:0]    os_clamp;
  logic [3:0]    widx_q, widx_d;
  logic          phase_q, phase_d;
  logic [15:0]   db_q, db_d;
  logic          trigger;
  logic [FAW:0]  fifo_free;
  logic [7:0]    push_byte;

  assign os_clamp  = (os_sel_i > OSMAX) ? OSMAX : os_sel_i;
  assign period_m1 = (BASE << os_q) - ONE;
  assign trigger   = en_i && (timer_q == '0) && (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_d     = cnt_q;
    cnt_lat_d = cnt_lat_q;
    os_d      = os_q;
    widx_d    = widx_q;
    phase_d   = phase_q;
    db_d      = db_q;

    if (en_i) timer_d = (timer_q == period_m1) ? '0 : timer_q + ONE;

    // Skipped packets still consume a counter value and latch os_sel.
    if (trigger) begin
      os_d  = os_clamp;
      cnt_d = cnt_q + 16'd1;
      if (fifo_free >= NEED) begin
        state_d   = SEND;
        cnt_lat_d = cnt_q;
        widx_d    = '0;
        phase_d   = 1'b0;
        db_d      = pkt_word(4'd0, os_clamp, cnt_q);
      end
    end

    if (state_q == SEND) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        if (widx_q == LAST) begin
          state_d = IDLE;
        end else begin
          widx_d = widx_q + 4'd1;
          db_d   = pkt_word(widx_q + 4'd1, os_q, cnt_lat_q);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      cnt_q     <= '0;
      cnt_lat_q <= '0;
      os_q      <= '0;
      widx_q    <= '0;
      phase_q   <= 1'b0;
      db_q      <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cnt_q     <= cnt_d;
      cnt_lat_q <= cnt_lat_d;
      os_q      <= os_d;
      widx_q    <= widx_d;
      phase_q   <= phase_d;
      db_q      <= db_d;
    end
  end

  assign db_o      = db_q;
  assign rdreq_o   = (state_q == SEND);
  assign wrclk_o   = (state_q == SEND) && phase_q;
  assign push_byte = phase_q ? db_q[7:0] : db_q[15:8];

  daq_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (reset_i),
    .push_i     (rdreq_o),
    .push_data_i(push_byte),
    .pop_i      (fifo_out_req),
    .empty_o    (fifo_out_empty),
    .data_o     (fifo_out_data),
    .free_o     (fifo_free)
  );

endmodule

// File: tb/tb_daq_packetizer.sv
// Directed bench for daq_packetizer: packet contents, timing, FIFO overflow/drain, os_sel, en and reset.
`timescale 1ns/1ps
module tb_daq_packetizer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [2:0]  os_sel_i = 3'd0;
  logic        en_i = 1'b0;
  logic [15:0] db_o;
  logic        rdreq_o;
  logic        wrclk_o;
  logic        fifo_out_empty;
  logic        fifo_out_req = 1'b0;
  logic [7:0]  fifo_out_data;

  int errors = 0;
  int checks = 0;

  logic [15:0] pkt0 [11] = '{16'hA500, 16'h0000, 16'h0000, 16'h2000, 16'h4000, 16'h6000,
                             16'h8000, 16'hA000, 16'hC000, 16'hE000, 16'h0000};
  logic [15:0] pkt1 [11] = '{16'hA500, 16'h0001, 16'h0001, 16'h2001, 16'h4001, 16'h6001,
                             16'h8001, 16'hA001, 16'hC001, 16'hE001, 16'h0001};

  always #2.5 clk_i = ~clk_i;

  daq_packetizer #(.BASE_PERIOD(1000), .FIFO_DEPTH(64)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .os_sel_i      (os_sel_i),
    .en_i          (en_i),
    .db_o          (db_o),
    .rdreq_o       (rdreq_o),
    .wrclk_o       (wrclk_o),
    .fifo_out_empty(fifo_out_empty),
    .fifo_out_req  (fifo_out_req),
    .fifo_out_data (fifo_out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_db"},    db_o, 16'h0000);
    check({tag, "_rdreq"}, rdreq_o, 1'b0);
    check({tag, "_wrclk"}, wrclk_o, 1'b0);
    check({tag, "_empty"}, fifo_out_empty, 1'b1);
    check({tag, "_data"},  fifo_out_data, 8'h00);
  endtask

  task automatic wait_rdreq(input int max, output int n, output bit seen);
    n = 0;
    while (!rdreq_o && n < max) begin
      @(negedge clk_i);
      n++;
    end
    seen = rdreq_o;
  endtask

  task automatic check_packet(input string tag, input bit second);
    logic [15:0] w;
    for (int i = 0; i < 11; i++) begin
      w = second ? pkt1[i] : pkt0[i];
      check($sformatf("%s_w%0d_a_db", tag, i), db_o, w);
      check($sformatf("%s_w%0d_a_strb", tag, i), {rdreq_o, wrclk_o}, 2'b10);
      @(negedge clk_i);
      check($sformatf("%s_w%0d_b_db", tag, i), db_o, w);
      check($sformatf("%s_w%0d_b_strb", tag, i), {rdreq_o, wrclk_o}, 2'b11);
      @(negedge clk_i);
    end
    check({tag, "_idle_rdreq"}, rdreq_o, 1'b0);
    check({tag, "_hold_db"}, db_o, w);
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [15:0] w;
    w = (i < 22) ? pkt0[(i % 22) / 2] : pkt1[(i % 22) / 2];
    return (i % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  initial begin
    int n;
    bit seen;

    // Test 1: reset and first packet
    #1 reset_i = 1'b0;
    en_i = 1'b1;
    os_sel_i = 3'd0;
    #4 check_reset("rst0");
    #6;
    @(negedge clk_i) reset_i = 1'b1;
    wait_rdreq(50, n, seen);
    check("p0_start", seen, 1'b1);
    check_packet("p0", 1'b0);

    // Test 2: second packet one period later
    wait_rdreq(1200, n, seen);
    check("p1_start", seen, 1'b1);
    check("p1_period", 22 + n, 1000);
    check_packet("p1", 1'b1);

    // Test 3: FIFO nearly full, third packet skipped
    check("fifo_full_empty", fifo_out_empty, 1'b0);
    check("fifo_full_head", fifo_out_data, 8'hA5);
    wait_rdreq(1200, n, seen);
    check("p2_skipped", seen, 1'b0);

    // Test 4: drain in order, then request while empty
    for (int i = 0; i < 44; i++) begin
      check($sformatf("drain%0d_empty", i), fifo_out_empty, 1'b0);
      check($sformatf("drain%0d_data", i), fifo_out_data, exp_byte(i));
      fifo_out_req = 1'b1;
      @(negedge clk_i);
    end
    fifo_out_req = 1'b0;
    check("drained_empty", fifo_out_empty, 1'b1);
    check("drained_data", fifo_out_data, 8'h01);
    fifo_out_req = 1'b1;
    @(negedge clk_i);
    fifo_out_req = 1'b0;
    check("empty_req_empty", fifo_out_empty, 1'b1);
    check("empty_req_data", fifo_out_data, 8'h01);

    wait_rdreq(1000, n, seen);
    check("p3_start", seen, 1'b1);
    check("p3_w0", db_o, 16'hA500);
    repeat (2) @(negedge clk_i);
    check("p3_w1", db_o, 16'h0003);

    // Test 5: oversampling 3 then 7 (clamped to 6)
    fifo_out_req = 1'b1;
    reset_i = 1'b0;
    os_sel_i = 3'd3;
    #1 check_reset("rst1");
    #9;
    @(negedge clk_i) reset_i = 1'b1;
    wait_rdreq(50, n, seen);
    check("os3_start", seen, 1'b1);
    check("os3_hdr", db_o, 16'hA503);
    repeat (22) @(negedge clk_i);
    os_sel_i = 3'd7;
    wait_rdreq(9000, n, seen);
    check("os3_seen", seen, 1'b1);
    check("os3_period", 22 + n, 8000);
    check("os7_hdr", db_o, 16'hA506);
    repeat (22) @(negedge clk_i);
    wait_rdreq(65000, n, seen);
    check("os6_seen", seen, 1'b1);
    check("os6_period", 22 + n, 64000);
    check("os6_hdr", db_o, 16'hA506);

    // Test 6: en drop mid-packet, resume, then reset mid-packet
    reset_i = 1'b0;
    os_sel_i = 3'd0;
    #10;
    @(negedge clk_i) reset_i = 1'b1;
    wait_rdreq(50, n, seen);
    check("en_start", seen, 1'b1);
    repeat (10) @(negedge clk_i);
    en_i = 1'b0;
    repeat (8) @(negedge clk_i);
    check("en_w9_db", db_o, 16'hE000);
    check("en_w9_strb", {rdreq_o, wrclk_o}, 2'b10);
    repeat (2) @(negedge clk_i);
    check("en_w10_db", db_o, 16'h0000);
    check("en_w10_a", {rdreq_o, wrclk_o}, 2'b10);
    @(negedge clk_i);
    check("en_w10_b", {rdreq_o, wrclk_o}, 2'b11);
    @(negedge clk_i);
    check("en_done", rdreq_o, 1'b0);
    wait_rdreq(1500, n, seen);
    check("en_off_quiet", seen, 1'b0);
    en_i = 1'b1;
    wait_rdreq(1100, n, seen);
    check("resume_seen", seen, 1'b1);
    check("resume_delay", n, 990);
    check("resume_hdr", db_o, 16'hA500);
    repeat (5) @(negedge clk_i);
    check("resume_w2_db", db_o, 16'h0001);
    #1 reset_i = 1'b0;
    #0.5 check_reset("rst_mid");
    #5 reset_i = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/daq_packetizer.md
Name: daq_packetizer

Overview:
Single-clock DAQ packet generator for the Platypus acquisition path. At a sample rate set by the oversampling select, it builds an 11-word packet: a header, a sample counter, 8 channel words and a checksum. Each packet is streamed as 16-bit words with a write strobe/clock for a downstream word FIFO. The same words are also split into bytes and pushed into an internal byte FIFO, which the host-side reader drains (USB/FT-side byte interface).

Parameters:
BASE_PERIOD, 1000, clk_i cycles between packets at os_sel_i=0 (5 us at 200 MHz); must be ≥ 32.
FIFO_DEPTH, 64, byte FIFO depth; power of two, ≥ 32.

Ports:
clk_i  in  1  system clock (200 MHz); every port is synchronous to it.
reset_i  in  1  asynchronous, active-low reset.
os_sel_i  in  3  oversampling select; values 7 are treated as 6.
en_i  in  1  enables packet generation.
db_o  out  16  current packet word.
rdreq_o  out  1  high while db_o carries a valid word.
wrclk_o  out  1  write clock/strobe for db_o; rises mid-word.
fifo_out_empty  out  1  byte FIFO empty.
fifo_out_req  in  1  pop request for the byte FIFO.
fifo_out_data  out  8  head byte of the byte FIFO (show-ahead).

Behaviour:
- Reset (reset_i=0, asynchronous): db_o=0, rdreq_o=0, wrclk_o=0, fifo_out_data=0, fifo_out_empty=1. Period timer=0, sample counter=0, FSM=IDLE, FIFO pointers cleared.
- Period: P = BASE_PERIOD << min(os_sel_i,6).
  - The timer counts 0..P-1 and wraps; it advances only while en_i=1.
  - Trigger fires when timer==0 and en_i=1 and FSM==IDLE.
  - os_sel_i is latched at the trigger. P uses the latched value and applies from that packet onward.
- FSM states: IDLE → (trigger) → SEND → (word 10, second cycle done) → IDLE.
- Packet words (W0..W10), using CNT = the 16-bit sample counter value at the trigger:
  - W0 = {8'hA5, 5'b0, os_sel_latched}.
  - W1 = CNT.
  - W2+k = {k[2:0], CNT[12:0]} for k = 0..7.
  - W10 = XOR of W1..W9.
- Word timing: each word holds db_o for exactly 2 cycles.
  - Cycle A: rdreq_o=1, wrclk_o=0.
  - Cycle B: rdreq_o=1, wrclk_o=1.
  - The first word appears the cycle after the trigger.
  - A packet takes 22 cycles back to back. rdreq_o is low between packets and db_o holds its last value.
- Sample counter increments by 1 (wrapping FFFF→0000) at every trigger, including skipped packets.
- Byte FIFO push: cycle A pushes W[15:8], cycle B pushes W[7:0] (big-endian).
- Overflow rule: at the trigger, if free space < 22 bytes, the whole packet is skipped. No db_o/rdreq_o activity and no FIFO writes occur for it. Packets are never truncated.
- Byte FIFO read: fifo_out_data always shows the head byte when not empty.
  - fifo_out_req=1 at a clock edge pops one byte.
  - A request while empty is ignored; fifo_out_data is unchanged.
  - Simultaneous push and pop are both honoured.
  - fifo_out_empty updates the cycle after the last pop.
- en_i deassert mid-packet: the current packet completes, then no further triggers. On re-enable the timer resumes from its held value.
- Reset mid-packet aborts immediately. All FIFO contents are lost.

Decomposition:
Package daq_packetizer_pkg holds:
- HDR byte 8'hA5
- PKT_WORDS = 11
- PKT_BYTES = 22
- MAX_OS = 6
- FSM state enum {IDLE, SEND}

Sub-module daq_byte_fifo (single-clock, show-ahead, FIFO_DEPTH parameter, exports free-space count). The packetizer FSM, timer and checksum stay in the top level.

Test Plan:
1. Reset low 10 ns, en_i=1, os_sel_i=0. Required: db_o sequence A500, 0000, 0000, 2000, 4000, 6000, 8000, A000, C000, E000, 0000. Each word lasts 2 cycles with rdreq_o=1 and wrclk_o pattern 0,1.
2. Continue the same run. Required: second packet starts exactly 1000 cycles after the first, with W1=0001, channel words 0001, 2001, …, E001, and checksum W10=0001.
3. fifo_out_req held low. Required: after 2 packets, FIFO holds 44 bytes beginning A5 00 00 00 00 00 20 00. The third trigger is skipped (free 20 < 22), and the fourth packet carries W1=0003.
4. fifo_out_req = !fifo_out_empty. Required: bytes read in order A5,00,00,00,… with no loss or duplication. fifo_out_empty returns to 1 after the last byte. A request while empty leaves fifo_out_data unchanged.
5. os_sel_i=3 at reset, switched to 7 after the first packet. Required: first period 8000 cycles; the next packet header is A506 and the following period is 64000 cycles.
6. en_i dropped at word 5 of a packet. Required: the packet completes to W10 and no further rdreq_o activity occurs. reset_i pulsed low mid-packet forces all outputs to their reset values immediately.
